// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command-path controller: FSM encoding,
// response-type codes and bit positions inside the command and response frames.
package sd_cmd_pkg;

    localparam logic [5:0] ST_IDLE       = 6'b000001;
    localparam logic [5:0] ST_WAIT_READY = 6'b000010;
    localparam logic [5:0] ST_SEND       = 6'b000100;
    localparam logic [5:0] ST_WAIT_RESP  = 6'b001000;
    localparam logic [5:0] ST_ACK        = 6'b010000;
    localparam logic [5:0] ST_DONE       = 6'b100000;

    localparam logic [1:0] RT_NONE   = 2'b00;
    localparam logic [1:0] RT_SHORT  = 2'b01;
    localparam logic [1:0] RT_LONG   = 2'b10;
    localparam logic [1:0] RT_SHORT2 = 2'b11;

    localparam int START_BIT   = 39;
    localparam int TX_BIT      = 38;
    localparam int IDX_MSB     = 37;
    localparam int IDX_LSB     = 32;
    localparam int RSP_IDX_MSB = 45;
    localparam int RSP_IDX_LSB = 40;
    localparam int RSP_ARG_MSB = 39;
    localparam int RSP_ARG_LSB = 8;

    function automatic logic resp_is_short(input logic [1:0] rt);
        return (rt == RT_SHORT) || (rt == RT_SHORT2);
    endfunction

    function automatic logic resp_is_long(input logic [1:0] rt);
        return (rt == RT_LONG);
    endfunction

endpackage

// File: rtl/sd_cmd_timeout.sv
// Response-wait counter: cleared by load_i, counts while enable_i, and flags
// expire_o on the last cycle allowed by limit_i (a limit of 0 behaves like 1).
module sd_cmd_timeout #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expire_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   next_s;

    // next count and expiry; the extra bit keeps the compare free of wrap-around
    always_comb begin
        next_s   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        expire_o = enable_i && (next_s >= {1'b0, limit_i});
        if (load_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = next_s[CNT_W-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_cmd_controller.sv
// SD host command-path controller: frames a command for the CMD-line serialiser,
// waits for the response with timeout and retry, and captures/validates it.
module sd_cmd_controller
    import sd_cmd_pkg::*;
#(
    parameter int ARG_W       = 32,
    parameter int IDX_W       = 6,
    parameter int RESP_W      = 128,
    parameter int TIMEOUT_W   = 16,
    parameter int MAX_RETRIES = 2,
    parameter int CHECK_INDEX = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 new_command,
    input  logic [IDX_W-1:0]     cmd_index,
    input  logic [ARG_W-1:0]     cmd_argument,
    input  logic [1:0]           resp_type,
    input  logic                 timeout_enable,
    input  logic [TIMEOUT_W-1:0] timeout_value,
    input  logic                 serial_ready,
    input  logic                 strobe_in,
    input  logic                 ack_in,
    input  logic [135:0]         cmd_in,
    output logic [39:0]          cmd_out,
    output logic                 strobe_out,
    output logic                 ack_out,
    output logic                 idle_out,
    output logic                 busy,
    output logic [RESP_W-1:0]    response,
    output logic                 command_complete,
    output logic                 command_index_error,
    output logic                 timeout_error,
    output logic [2:0]           retry_count
);
    localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRIES);

    logic [5:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           rtype_q, rtype_d;
    logic                 tmo_en_q, tmo_en_d;
    logic [TIMEOUT_W-1:0] tmo_val_q, tmo_val_d;
    logic [39:0]          frame_q, frame_d;
    logic [RESP_W-1:0]    resp_q, resp_d;
    logic [2:0]           retry_q, retry_d;
    logic                 strobe_q, strobe_d;
    logic                 ack_q, ack_d;
    logic                 idle_q, idle_d;
    logic                 busy_q, busy_d;
    logic                 complete_q, complete_d;
    logic                 idx_err_q, idx_err_d;
    logic                 tmo_err_q, tmo_err_d;
    logic                 expire_s;
    logic                 idle_pulse_s;
    logic                 tmo_load_s;
    logic                 tmo_run_s;
    logic                 unused_rsp_s;

    // the response frame's top byte (start/tx/reserved) is never captured
    assign unused_rsp_s = ^cmd_in[135:128];

    assign tmo_load_s = (state_q == ST_SEND);
    assign tmo_run_s  = (state_q == ST_WAIT_RESP) && tmo_en_q;

    sd_cmd_timeout #(
        .CNT_W (TIMEOUT_W)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .load_i   (tmo_load_s),
        .enable_i (tmo_run_s),
        .limit_i  (tmo_val_q),
        .expire_o (expire_s)
    );

    // FSM next state and datapath; strobe_out is high for exactly the WAIT_RESP cycles
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rtype_d      = rtype_q;
        tmo_en_d     = tmo_en_q;
        tmo_val_d    = tmo_val_q;
        frame_d      = frame_q;
        resp_d       = resp_q;
        retry_d      = retry_q;
        idx_err_d    = idx_err_q;
        tmo_err_d    = tmo_err_q;
        strobe_d     = 1'b0;
        ack_d        = 1'b0;
        idle_pulse_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_command) begin
                    idx_d                    = cmd_index;
                    rtype_d                  = resp_type;
                    tmo_en_d                 = timeout_enable;
                    tmo_val_d                = timeout_value;
                    frame_d                  = 40'd0;
                    frame_d[START_BIT]       = 1'b0;
                    frame_d[TX_BIT]          = 1'b1;
                    frame_d[IDX_MSB:IDX_LSB] = 6'(cmd_index);
                    frame_d[IDX_LSB-1:0]     = 32'(cmd_argument);
                    idx_err_d                = 1'b0;
                    tmo_err_d                = 1'b0;
                    retry_d                  = 3'd0;
                    state_d                  = ST_WAIT_READY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_READY: begin
                if (serial_ready) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_SEND: begin
                strobe_d = 1'b1;
                state_d  = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (strobe_in) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                    if (resp_is_long(rtype_q)) begin
                        resp_d         = '0;
                        resp_d[127:0]  = cmd_in[127:0];
                    end else if (resp_is_short(rtype_q)) begin
                        resp_d         = '0;
                        resp_d[31:0]   = cmd_in[RSP_ARG_MSB:RSP_ARG_LSB];
                        if ((CHECK_INDEX != 0) && (cmd_in[RSP_IDX_MSB:RSP_IDX_LSB] != 6'(idx_q))) begin
                            idx_err_d = 1'b1;
                        end else begin
                            idx_err_d = idx_err_q;
                        end
                    end else begin
                        resp_d = resp_q;
                    end
                end else if (expire_s) begin
                    idle_pulse_s = 1'b1;
                    if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + 3'd1;
                        state_d = ST_WAIT_READY;
                    end else begin
                        tmo_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else begin
                    strobe_d = 1'b1;
                end
            end
            ST_ACK: begin
                if (ack_in) begin
                    state_d = ST_DONE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        idle_d     = (state_d == ST_IDLE) || idle_pulse_s;
        busy_d     = (state_d != ST_IDLE);
        complete_d = (state_d == ST_DONE);
    end

    // state and registered outputs; reset abandons any transfer in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rtype_q    <= 2'b00;
            tmo_en_q   <= 1'b0;
            tmo_val_q  <= '0;
            frame_q    <= 40'd0;
            resp_q     <= '0;
            retry_q    <= 3'd0;
            strobe_q   <= 1'b0;
            ack_q      <= 1'b0;
            idle_q     <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            idx_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rtype_q    <= rtype_d;
            tmo_en_q   <= tmo_en_d;
            tmo_val_q  <= tmo_val_d;
            frame_q    <= frame_d;
            resp_q     <= resp_d;
            retry_q    <= retry_d;
            strobe_q   <= strobe_d;
            ack_q      <= ack_d;
            idle_q     <= idle_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            idx_err_q  <= idx_err_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign cmd_out             = frame_q;
    assign strobe_out          = strobe_q;
    assign ack_out             = ack_q;
    assign idle_out            = idle_q;
    assign busy                = busy_q;
    assign response            = resp_q;
    assign command_complete    = complete_q;
    assign command_index_error = idx_err_q;
    assign timeout_error       = tmo_err_q;
    assign retry_count         = retry_q;

endmodule
